// File: rtl/rtc_bus_timing_pkg.sv
// -----------------------------------------------------------------------------
// rtc_bus_pkg
// Shared definitions for the RTC multiplexed-bus timing generator:
//   - transaction mode encoding and the frame count each mode runs
//   - strobe window bounds, expressed as cont_32 step indices
//   - the frame index where a write transaction turns into read cycles
//   - the sequencer state type
// Optional feature macro: FRAME_GAP_EN adds the ST_GAP state.
// -----------------------------------------------------------------------------
package rtc_bus_pkg;

  // Mode carried in out_port[1:0] when a transaction is started.
  typedef enum logic [1:0] {
    MODE_INIT  = 2'b00,
    MODE_READ  = 2'b01,
    MODE_WRITE = 2'b10,
    MODE_MODS  = 2'b11
  } mode_t;

  // Number of 32-step frames per transaction for each mode.
  localparam logic [4:0] FRAMES_INIT  = 5'd1;
  localparam logic [4:0] FRAMES_READ  = 5'd10;
  localparam logic [4:0] FRAMES_WRITE = 5'd17;
  localparam logic [4:0] FRAMES_MODS  = 5'd1;

  // Strobe windows (inclusive cont_32 bounds).
  localparam logic [4:0] AD_LO      = 5'd1;
  localparam logic [4:0] AD_HI      = 5'd10;
  localparam logic [4:0] CS_A_LO    = 5'd2;
  localparam logic [4:0] CS_A_HI    = 5'd9;
  localparam logic [4:0] CS_D_LO    = 5'd14;
  localparam logic [4:0] CS_D_HI    = 5'd29;
  localparam logic [4:0] WR_A_LO    = 5'd3;
  localparam logic [4:0] WR_A_HI    = 5'd8;
  localparam logic [4:0] WR_D_LO    = 5'd16;
  localparam logic [4:0] WR_D_HI    = 5'd27;
  localparam logic [4:0] RD_D_LO    = 5'd16;
  localparam logic [4:0] RD_D_HI    = 5'd29;
  localparam logic [4:0] LE_LO      = 5'd24;
  localparam logic [4:0] LE_HI      = 5'd28;

  // In a write transaction, frames below this index write data; from this
  // frame on the RTC is read back.
  localparam logic [4:0] SPLIT_FRAME = 5'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_FRAME  = 3'd2,
`ifdef FRAME_GAP_EN
    ST_GAP    = 3'd3,
`endif
    ST_FINISH = 3'd4
  } state_t;

  function automatic logic [4:0] frames_for_mode(input mode_t mode);
    logic [4:0] frames;
    case (mode)
      MODE_INIT:  frames = FRAMES_INIT;
      MODE_READ:  frames = FRAMES_READ;
      MODE_WRITE: frames = FRAMES_WRITE;
      default:    frames = FRAMES_MODS;
    endcase
    return frames;
  endfunction

  function automatic logic in_window(input logic [4:0] v,
                                     input logic [4:0] lo,
                                     input logic [4:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // A frame drives data onto the bus unless it is a read-type cycle.
  function automatic logic is_write_cycle(input mode_t mode,
                                          input logic [4:0] frame);
    logic wr;
    case (mode)
      MODE_READ:  wr = 1'b0;
      MODE_WRITE: wr = (frame < SPLIT_FRAME);
      default:    wr = 1'b1;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/rtc_bus_timing_if.sv
// -----------------------------------------------------------------------------
// rtc_bus_timing_if
// Bundles the PicoBlaze write port and all timing/strobe outputs of
// rtc_bus_timing.
//   master : PicoBlaze side / consumer (drives en_01, port_id, out_port)
//   slave  : rtc_bus_timing (drives counters, pulses and RTC strobes)
// -----------------------------------------------------------------------------
interface rtc_bus_timing_if;
  logic       en_01;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic [4:0] cont_32;
  logic       enable_cont_32;
  logic [4:0] cont17;
  logic       LE;
  logic       sync;
  logic       AD_n;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       busy;
  logic       done;

  modport master (
    output en_01, port_id, out_port,
    input  cont_32, enable_cont_32, cont17, LE, sync,
    input  AD_n, CS_n, RD_n, WR_n, busy, done
  );

  modport slave (
    input  en_01, port_id, out_port,
    output cont_32, enable_cont_32, cont17, LE, sync,
    output AD_n, CS_n, RD_n, WR_n, busy, done
  );
endinterface

// File: rtl/rtc_bus_timing_strobe_decode.sv
// -----------------------------------------------------------------------------
// rtc_strobe_decode
// Registered decoder turning (step, mode, frame) into the RTC strobes and LE.
// The caller presents the values the counters will hold in the next cycle,
// so the registered strobes line up with cont_32/cont17 as seen outside.
// Ports:
//   reloj, resetM  clock / async active-low reset (strobes high, LE low)
//   in_frame       next cycle is a FRAME cycle; otherwise everything idles
//   cont_32        next step index
//   cont17         next frame index
//   mode           next latched mode
//   AD_n..WR_n, LE registered outputs
// -----------------------------------------------------------------------------
module rtc_strobe_decode
  import rtc_bus_pkg::*;
(
  input  logic       reloj,
  input  logic       resetM,
  input  logic       in_frame,
  input  logic [4:0] cont_32,
  input  logic [4:0] cont17,
  input  mode_t      mode,
  output logic       AD_n,
  output logic       CS_n,
  output logic       RD_n,
  output logic       WR_n,
  output logic       LE
);

  logic write_cycle;
  logic ad_act;
  logic cs_act;
  logic wr_act;
  logic rd_act;
  logic le_act;

  always_comb begin
    write_cycle = is_write_cycle(mode, cont17);
    ad_act = in_frame && in_window(cont_32, AD_LO, AD_HI);
    cs_act = in_frame && (in_window(cont_32, CS_A_LO, CS_A_HI) ||
                          in_window(cont_32, CS_D_LO, CS_D_HI));
    // Address write happens in every frame; data write only in write cycles.
    wr_act = in_frame && (in_window(cont_32, WR_A_LO, WR_A_HI) ||
                          (write_cycle && in_window(cont_32, WR_D_LO, WR_D_HI)));
    rd_act = in_frame && !write_cycle && in_window(cont_32, RD_D_LO, RD_D_HI);
    le_act = in_frame && (mode == MODE_WRITE) && (cont17 >= SPLIT_FRAME) &&
             in_window(cont_32, LE_LO, LE_HI);
  end

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      AD_n <= 1'b1;
      CS_n <= 1'b1;
      RD_n <= 1'b1;
      WR_n <= 1'b1;
      LE   <= 1'b0;
    end else begin
      AD_n <= !ad_act;
      CS_n <= !cs_act;
      RD_n <= !rd_act;
      WR_n <= !wr_act;
      LE   <= le_act;
    end
  end

endmodule

// File: rtl/rtc_bus_timing.sv
// -----------------------------------------------------------------------------
// rtc_bus_timing
// Timing generator for the RTC multiplexed address/data bus. A PicoBlaze
// write to START_PORT launches a transaction of 1/10/17/1 frames (by mode);
// each frame is 32 steps of TICK_DIV reloj cycles.
// Ports:
//   reloj   system clock (rising edge)
//   resetM  asynchronous active-low reset
//   bus     rtc_bus_timing_if.slave: en_01/port_id/out_port in; cont_32,
//           enable_cont_32, cont17, LE, sync, AD_n, CS_n, RD_n, WR_n, busy,
//           done out
// Optional feature macro: FRAME_GAP_EN inserts GAP_TICKS idle steps between
// frames of a transaction.
// -----------------------------------------------------------------------------
module rtc_bus_timing
  import rtc_bus_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4,
  parameter logic [7:0]  START_PORT = 8'h11
`ifdef FRAME_GAP_EN
  , parameter int unsigned GAP_TICKS = 4
`endif
) (
  input  logic              reloj,
  input  logic              resetM,
  rtc_bus_timing_if.slave   bus
);

  localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
`ifdef FRAME_GAP_EN
  localparam logic [7:0] GAP_LAST   = 8'(GAP_TICKS - 1);
`endif

  state_t     state_reg,   state_next;
  mode_t      mode_reg,    mode_next;
  logic [4:0] frames_reg,  frames_next;
  logic [7:0] presc_reg,   presc_next;
  logic [4:0] cont_32_reg, cont_32_next;
  logic [4:0] cont17_reg,  cont17_next;
`ifdef FRAME_GAP_EN
  logic [7:0] gap_reg,     gap_next;
`endif

  logic start;
  logic step_end;
  logic frame_end;
  logic unused_out_port_bits;

  assign start     = bus.en_01 && (bus.port_id == START_PORT);
  assign step_end  = (presc_reg == PRESC_LAST);
  assign frame_end = (state_reg == ST_FRAME) && (cont_32_reg == 5'd31) && step_end;
  assign unused_out_port_bits = ^bus.out_port[7:2];

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state_reg   <= ST_IDLE;
      mode_reg    <= MODE_INIT;
      frames_reg  <= 5'd0;
      presc_reg   <= 8'd0;
      cont_32_reg <= 5'd0;
      cont17_reg  <= 5'd0;
`ifdef FRAME_GAP_EN
      gap_reg     <= 8'd0;
`endif
    end else begin
      state_reg   <= state_next;
      mode_reg    <= mode_next;
      frames_reg  <= frames_next;
      presc_reg   <= presc_next;
      cont_32_reg <= cont_32_next;
      cont17_reg  <= cont17_next;
`ifdef FRAME_GAP_EN
      gap_reg     <= gap_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    mode_next    = mode_reg;
    frames_next  = frames_reg;
    presc_next   = presc_reg;
    cont_32_next = cont_32_reg;
    cont17_next  = cont17_reg;
`ifdef FRAME_GAP_EN
    gap_next     = gap_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        presc_next   = 8'd0;
        cont_32_next = 5'd0;
        cont17_next  = 5'd0;
        // Mode and frame count are only captured here, so a start request
        // during a transaction cannot disturb it.
        if (start) begin
          mode_next   = mode_t'(bus.out_port[1:0]);
          frames_next = frames_for_mode(mode_t'(bus.out_port[1:0]));
          state_next  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        presc_next   = 8'd0;
        cont_32_next = 5'd0;
        cont17_next  = 5'd0;
        state_next   = ST_FRAME;
      end

      ST_FRAME: begin
        if (step_end) begin
          presc_next = 8'd0;
          if (cont_32_reg == 5'd31) begin
            cont_32_next = 5'd0;
            if (cont17_reg == frames_reg - 5'd1) begin
              cont17_next = 5'd0;
              state_next  = ST_FINISH;
            end else begin
              cont17_next = cont17_reg + 5'd1;
`ifdef FRAME_GAP_EN
              gap_next   = 8'd0;
              state_next = ST_GAP;
`endif
            end
          end else begin
            cont_32_next = cont_32_reg + 5'd1;
          end
        end else begin
          presc_next = presc_reg + 8'd1;
        end
      end

`ifdef FRAME_GAP_EN
      // Gap steps reuse the prescaler so each one is TICK_DIV cycles long.
      ST_GAP: begin
        cont_32_next = 5'd0;
        if (step_end) begin
          presc_next = 8'd0;
          if (gap_reg == GAP_LAST) begin
            state_next = ST_FRAME;
          end else begin
            gap_next = gap_reg + 8'd1;
          end
        end else begin
          presc_next = presc_reg + 8'd1;
        end
      end
`endif

      ST_FINISH: begin
        presc_next   = 8'd0;
        cont_32_next = 5'd0;
        cont17_next  = 5'd0;
        state_next   = ST_IDLE;
      end

      default: begin
        presc_next   = 8'd0;
        cont_32_next = 5'd0;
        cont17_next  = 5'd0;
        state_next   = ST_IDLE;
      end
    endcase
  end

  // Fed with next-cycle values so the registered strobes match cont_32.
  rtc_strobe_decode u_strobe_decode (
    .reloj    (reloj),
    .resetM   (resetM),
    .in_frame (state_next == ST_FRAME),
    .cont_32  (cont_32_next),
    .cont17   (cont17_next),
    .mode     (mode_next),
    .AD_n     (bus.AD_n),
    .CS_n     (bus.CS_n),
    .RD_n     (bus.RD_n),
    .WR_n     (bus.WR_n),
    .LE       (bus.LE)
  );

  assign bus.cont_32        = cont_32_reg;
  assign bus.cont17         = cont17_reg;
  assign bus.enable_cont_32 = frame_end;
  assign bus.sync           = (state_reg == ST_LOAD);
  assign bus.done           = (state_reg == ST_FINISH);
`ifdef FRAME_GAP_EN
  assign bus.busy = (state_reg == ST_LOAD) || (state_reg == ST_FRAME) ||
                    (state_reg == ST_GAP);
`else
  assign bus.busy = (state_reg == ST_LOAD) || (state_reg == ST_FRAME);
`endif

endmodule

// File: tb/tb_rtc_bus_timing.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_timing
// Directed bench for rtc_bus_timing with default parameters (TICK_DIV=4,
// START_PORT=8'h11, GAP_TICKS=4 when FRAME_GAP_EN is defined). Every reloj
// cycle of a transaction is compared against an independent model; the
// per-transaction frame count is tracked in a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_rtc_bus_timing;

  localparam int TD        = 4;
  localparam int FRAME_CYC = 32 * TD;
`ifdef FRAME_GAP_EN
  localparam int GAP_CYC   = 4 * TD;
`else
  localparam int GAP_CYC   = 0;
`endif

  typedef struct {
    logic [1:0] mode;
    int         frames;
  } txn_t;

  logic reloj  = 1'b0;
  logic resetM = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  txn_t exp_q[$];

  rtc_bus_timing_if bus ();

  rtc_bus_timing dut (
    .reloj  (reloj),
    .resetM (resetM),
    .bus    (bus)
  );

  always #5 reloj = ~reloj;

  // {cont_32, cont17, enable_cont_32, LE, sync, AD_n, CS_n, RD_n, WR_n, busy, done}
  logic [18:0] obs_vec;
  assign obs_vec = {bus.cont_32, bus.cont17, bus.enable_cont_32, bus.LE, bus.sync,
                    bus.AD_n, bus.CS_n, bus.RD_n, bus.WR_n, bus.busy, bus.done};

  function automatic logic [18:0] pack(input logic [4:0] c32, input logic [4:0] c17,
                                       input logic en, input logic le, input logic sy,
                                       input logic ad, input logic cs, input logic rd,
                                       input logic wr, input logic bz, input logic dn);
    return {c32, c17, en, le, sy, ad, cs, rd, wr, bz, dn};
  endfunction

  function automatic logic [18:0] idle_vec();
    return pack(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  // Expected outputs during a FRAME cycle at a given frame/step.
  function automatic logic [18:0] frame_vec(input logic [1:0] m, input int f,
                                            input int s, input logic en);
    logic wtype, ad_lo, cs_lo, rd_lo, wr_lo, le;
    wtype = (m == 2'd0) || (m == 2'd3) || ((m == 2'd2) && (f < 7));
    ad_lo = (s >= 1) && (s <= 10);
    cs_lo = ((s >= 2) && (s <= 9)) || ((s >= 14) && (s <= 29));
    wr_lo = ((s >= 3) && (s <= 8)) || (wtype && (s >= 16) && (s <= 27));
    rd_lo = !wtype && (s >= 16) && (s <= 29);
    le    = (m == 2'd2) && (f >= 7) && (s >= 24) && (s <= 28);
    return pack(5'(s), 5'(f), en, le, 1'b0, !ad_lo, !cs_lo, !rd_lo, !wr_lo, 1'b1, 1'b0);
  endfunction

  task automatic check_vec(input string tag, input logic [18:0] expv);
    checks++;
    assert (obs_vec === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_vec, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // RD_n and WR_n must never be low together.
  always @(negedge reloj) begin
    if (resetM) begin
      checks++;
      assert (!(bus.RD_n === 1'b0 && bus.WR_n === 1'b0)) else begin
        failures++;
        $error("FAIL rd_wr_overlap observed=RD_n%b/WR_n%b expected=not_both_low",
               bus.RD_n, bus.WR_n);
      end
    end
  end

  // Starts a transaction at the current negedge and checks every cycle until
  // idle. inject_c: frame-cycle index at which a second start is issued
  // (-1 none). abort_c: frame-cycle index after which reset is asserted.
  task automatic run_txn(input logic [1:0] m, input int inject_c, input int abort_c);
    int   frames;
    int   pulses;
    int   s;
    int   idx;
    bit   aborted;
    logic en;
    txn_t e;
    frames  = (m == 2'd1) ? 10 : (m == 2'd2) ? 17 : 1;
    pulses  = 0;
    aborted = 1'b0;
    bus.en_01    = 1'b1;
    bus.port_id  = 8'h11;
    bus.out_port = {6'b0, m};
    exp_q.push_back('{mode: m, frames: frames});
    @(negedge reloj);
    bus.en_01    = 1'b0;
    bus.out_port = 8'h00;
    check_vec($sformatf("load_m%0d", m),
              pack(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
    for (int f = 0; f < frames && !aborted; f++) begin
      for (int c = 0; c < FRAME_CYC; c++) begin
        @(negedge reloj);
        s   = c / TD;
        en  = (c == FRAME_CYC - 1);
        idx = f * FRAME_CYC + c;
        check_vec($sformatf("m%0d_f%0d_s%0d_p%0d", m, f, s, c % TD), frame_vec(m, f, s, en));
        if (bus.enable_cont_32 === 1'b1) pulses++;
        bus.en_01 = 1'b0;
        if (idx == inject_c) begin
          bus.en_01    = 1'b1;
          bus.port_id  = 8'h11;
          bus.out_port = 8'h02;
        end
        if (idx == abort_c) begin
          resetM = 1'b0;
          #1;
          check_vec($sformatf("async_abort_m%0d", m), idle_vec());
          aborted = 1'b1;
          break;
        end
      end
      if (!aborted && f < frames - 1) begin
        for (int g = 0; g < GAP_CYC; g++) begin
          @(negedge reloj);
          check_vec($sformatf("gap_m%0d_f%0d_c%0d", m, f, g),
                    pack(5'd0, 5'(f + 1), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0));
        end
      end
    end
    e = exp_q.pop_front();
    if (aborted) begin
      for (int r = 0; r < 3; r++) begin
        @(negedge reloj);
        check_vec("abort_hold", idle_vec());
      end
      resetM = 1'b1;
      for (int r = 0; r < 5; r++) begin
        @(negedge reloj);
        check_vec("abort_no_done", idle_vec());
      end
      check_int("abort_pulses", pulses, abort_c / FRAME_CYC);
    end else begin
      @(negedge reloj);
      check_vec($sformatf("finish_m%0d", m),
                pack(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1));
      check_int($sformatf("frame_pulses_m%0d", m), pulses, e.frames);
      @(negedge reloj);
      check_vec($sformatf("post_idle_m%0d", m), idle_vec());
    end
    $display("txn mode=%0d frames_expected=%0d enable_pulses=%0d aborted=%0d",
             m, e.frames, pulses, aborted);
  endtask

  initial begin
    bus.en_01    = 1'b0;
    bus.port_id  = 8'h00;
    bus.out_port = 8'h00;
    resetM       = 1'b0;

    // Reset state, then 100 idle cycles.
    @(negedge reloj);
    check_vec("reset_state", idle_vec());
    @(negedge reloj);
    resetM = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge reloj);
      check_vec("idle", idle_vec());
    end
    // Wrong port is not a start.
    bus.en_01   = 1'b1;
    bus.port_id = 8'h12;
    @(negedge reloj);
    bus.en_01   = 1'b0;
    @(negedge reloj);
    check_vec("wrong_port", idle_vec());

    run_txn(2'd1, -1, -1);                        // read, 10 frames
    run_txn(2'd2, -1, -1);                        // write, 17 frames
    run_txn(2'd0, -1, -1);                        // init, 1 frame
    run_txn(2'd3, -1, -1);                        // Mod_S, 1 frame
    run_txn(2'd1, 3 * FRAME_CYC + 20, -1);        // start while busy
    run_txn(2'd1, -1, FRAME_CYC + 20 * TD);       // reset at frame 1, step 20
    run_txn(2'd0, -1, -1);                        // recovery after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_bus_timing.md
Name: rtc_bus_timing

Overview:
- Timing generator for the multiplexed address/data bus of the RTC; sits directly upstream of the DIR_DATO mux/demux stage.
- Accepts a transaction start from the PicoBlaze out_port and runs a fixed number of 32-step bus frames.
- Drives the RTC strobes AD_n, CS_n, RD_n and WR_n.
- Supplies the mux stage with cont_32, enable_cont_32, cont17, LE and sync.

Parameters:
- TICK_DIV, 4: reloj cycles per cont_32 step (legal range 1..255).
- START_PORT, 8'h11: port_id that starts a transaction.
- GAP_TICKS, 4: idle steps between frames; used only when FRAME_GAP_EN is defined.

Ports:
- reloj  in  1  system clock; all logic on the rising edge.
- resetM  in  1  asynchronous, active-low reset.
- en_01  in  1  PicoBlaze write strobe.
- port_id  in  8  PicoBlaze port address.
- out_port  in  8  PicoBlaze write data; bits [1:0] give the mode.
- cont_32  out  5  step index within the current frame, 0..31.
- enable_cont_32  out  1  one-cycle pulse at the end of each frame.
- cont17  out  5  frame index within the current transaction.
- LE  out  1  read-latch enable, used in write mode only.
- sync  out  1  one-cycle pulse when a transaction starts.
- AD_n  out  1  RTC address strobe, active low.
- CS_n  out  1  RTC chip select, active low.
- RD_n  out  1  RTC read strobe, active low.
- WR_n  out  1  RTC write strobe, active low.
- busy  out  1  high while a transaction is in progress.
- done  out  1  one-cycle pulse after the last frame.

Behaviour:
- Reset (resetM=0, asynchronous):
  - FSM goes to IDLE; prescaler = 0.
  - cont_32 = 0, cont17 = 0.
  - enable_cont_32, LE, sync, busy, done = 0.
  - AD_n, CS_n, RD_n, WR_n = 1.
- Start condition: en_01=1 and port_id==START_PORT while in IDLE.
  - mode is latched from out_port[1:0].
  - The frame count is latched from the mode: 00 (init) = 1, 01 (read) = 10, 10 (write) = 17, 11 (Mod_S) = 1.
- Start while busy is ignored. The latched mode is not changed.
- FSM states: IDLE -> LOAD -> FRAME -> (GAP) -> FINISH -> IDLE.
  - LOAD lasts 1 cycle and asserts sync.
  - FRAME steps cont_32 once every TICK_DIV reloj cycles. The prescaler counts 0..TICK_DIV-1 and wraps.
  - At cont_32==31 on the last prescaler cycle:
    - enable_cont_32 = 1 for that single reloj cycle.
    - cont_32 wraps to 0 and cont17 increments.
    - If cont17 == frames-1, go to FINISH instead.
  - FINISH lasts 1 cycle: done=1, busy=0 from the next cycle, cont17 returns to 0.
- busy is 1 from LOAD through the last FRAME cycle.
- Strobes are registered and are functions of (cont_32, mode, cont17); all are deasserted outside FRAME.
  - AD_n = 0 for cont_32 in 1..10 (address phase).
  - CS_n = 0 for cont_32 in 2..9 and 14..29.
  - WR_n = 0 for cont_32 in 3..8 (address write).
  - Data phase:
    - Write-type cycle (modes 00 and 11, or mode 10 with cont17 < 7): WR_n = 0 for cont_32 in 16..27.
    - Read-type cycle (mode 01, or mode 10 with cont17 >= 7): RD_n = 0 for cont_32 in 16..29.
  - RD_n and WR_n are never low simultaneously (assertion in the bench).
- LE = 1 only when mode==10, cont17 >= 7 and cont_32 is in 24..28. This matches the downstream READ window.
- cont_32 and cont17 remain stable across the whole prescaler interval.
- Reset mid-transaction aborts immediately: strobes go high, done is not pulsed.

Optional Feature:
- Macro FRAME_GAP_EN.
- When defined: after each non-final frame, the GAP state holds for GAP_TICKS steps.
  - All strobes are high and cont_32 holds at 0.
  - busy stays 1 and enable_cont_32 is not pulsed during the gap.
- When undefined: there is no GAP state and frames are back-to-back.

Decomposition:
- Package rtc_bus_pkg contains:
  - The mode encoding (MODE_INIT, MODE_READ, MODE_WRITE, MODE_MODS).
  - Frame counts 1/10/17/1.
  - Strobe window bounds (AD 1..10, CS 2..9 / 14..29, WR 3..8 / 16..27, RD 16..29, LE 24..28).
  - The write/read split frame index, 7.
  - The FSM state typedef.
- Sub-module rtc_strobe_decode: a registered decoder of (cont_32, mode, cont17) into the four strobes and LE. The FSM and counters stay in the top level.

Test Plan:
- Reset/idle: release resetM, then 100 idle cycles -> all strobes 1, busy 0, cont_32 0, cont17 0.
- Read: en_01=1, port_id=8'h11, out_port=8'h01 -> sync 1 cycle later; 10 frames of 128 cycles each (TICK_DIV=4); 10 enable_cont_32 pulses; done at frame end; RD_n low for steps 16..29; WR_n low only for steps 3..8.
- Write: out_port=8'h02 -> 17 frames, cont17 0..16. Frames 0..6 have WR_n low for 16..27. Frames 7..16 have RD_n low for 16..29. LE is high only for steps 24..28 of frames 7..16.
- Init: out_port=8'h00 -> exactly 1 frame, done pulses, busy 0 after 1+128+1 cycles.
- Start while busy: second start at frame 3 of a read -> ignored; still 10 frames and mode unchanged. Reset asserted at cont_32=20 -> strobes 1 asynchronously, no done pulse.
- FRAME_GAP_EN (GAP_TICKS=4) on a read -> 16 reloj cycles of all-high strobes between frames; total busy = 10*128 + 9*16 + 1 cycles.
